mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one single-outstanding memory port among PORT_COUNT requesters (IF, MEM, DMA...).
//  Latches each port's read/write request, grants one at a time with rotating priority, and forwards it downstream.
//  Returns read data and a one-cycle done pulse to the owning port. Sits between the CPU stages and memory_controller.
// PARAMETERS
//  PORT_COUNT   4   number of requester ports (>=2)
//  ADDR_WIDTH   32  address width in bits
//  DATA_WIDTH   32  data width in bits; mask width MW = DATA_WIDTH/8
// PORTS
//  CLK          in   1               clock, all logic on rising edge
//  RST          in   1               synchronous reset, active-high
//  rw_flag_     in   2*PORT_COUNT    per-port request: 0 none, 1 read, 2 write, 3 treated as none
//  addr_        in   ADDR_WIDTH*PC   per-port address
//  write_data_  in   DATA_WIDTH*PC   per-port write data
//  write_mask_  in   MW*PC           per-port byte write mask
//  read_data_   out  DATA_WIDTH*PC   per-port last read result (held until next read on that port)
//  busy         out  PORT_COUNT      port has an accepted, uncompleted request
//  done         out  PORT_COUNT      one-cycle completion pulse per port
//  mem_rw_flag  out  2               downstream request, nonzero for exactly one cycle per issue
//  mem_addr     out  ADDR_WIDTH      downstream address, valid with mem_rw_flag
//  mem_wdata    out  DATA_WIDTH      downstream write data
//  mem_mask     out  MW              downstream write mask
//  mem_busy     in   1               downstream cannot accept an issue this cycle
//  mem_done     in   1               downstream completion pulse (read or write)
//  mem_rdata    in   DATA_WIDTH      downstream read data, valid with mem_done
// BEHAVIOUR
//  Reset (RST=1 at edge): busy=0, done=0, read_data_=0, mem_rw_flag=0, mem_addr/wdata/mask=0, all pending slots
//   cleared, rr pointer last=PORT_COUNT-1 (so port 0 has first priority), state=IDLE. Reset mid-transaction
//   abandons it; a later stray mem_done is ignored.
//  Accept: at edge where rw_flag[p] in {1,2} and busy[p]=0 -> pending slot p latches flag/addr/data/mask,
//   busy[p]=1 next cycle. rw_flag[p] while busy[p]=1 is ignored (requester re-presents after done).
//  Arbitration: among pending ports (pending slots only, never raw inputs), pick the first at or after last+1
//   modulo PORT_COUNT. All ports pending -> strict rotation 0,1,2,3,0...
//  FSM IDLE: if any pending and mem_busy=0 -> register mem_rw_flag/addr/wdata/mask from the winner's slot,
//   serv<=winner, state<=WAIT. mem_busy=1 -> no issue, outputs stay 0. mem_done in IDLE is ignored.
//  FSM WAIT: mem_rw_flag=0. On mem_done: done[serv]=1 next cycle, busy[serv]=0 same edge, slot cleared,
//   read_data_[serv]<=mem_rdata if the slot was a read (writes leave read_data_ unchanged), last<=serv, state<=IDLE.
//  Latency (idle system, downstream done k cycles after issue cycle): request at edge T -> mem_rw_flag high
//   in cycle T+2 -> mem_done at T+2+k -> done/busy-clear visible T+3+k. Back-to-back issue earliest one cycle
//   after done.
//  Simultaneous: done and a new accept on another port in the same edge are both honoured; a port whose done
//   pulses may be accepted again on the next edge (busy already 0).
//  Only one downstream transaction outstanding at any time; no reordering within a port.
// TESTING
//  1 Reset: RST high 2 cycles with rw_flag_=all 1 -> busy=0, done=0, mem_rw_flag=0; release -> port 0 granted first.
//  2 Single read: port 2 read addr 0x100, mem_done+mem_rdata=0xDEADBEEF 3 cycles after issue ->
//    mem_addr=0x100 at T+2, done[2] at T+6, read_data_[2]=0xDEADBEEF, busy[2] low from T+6.
//  3 Fairness: all 4 ports request reads together, re-request on each done -> grant sequence 0,1,2,3,0,1,2,3,
//    no port granted twice before the others.
//  4 Write: port 1 write addr 0x20 data 0x11223344 mask 4'b0011 -> mem_rw_flag=2 one cycle with those values,
//    done[1] after mem_done, read_data_[1] unchanged.
//  5 Backpressure: mem_busy=1 for 10 cycles with port 3 pending -> no issue, busy[3]=1 held; mem_busy=0 ->
//    issue next cycle; stray mem_done while IDLE -> no done pulse.
//  6 Reset mid-WAIT: assert RST after issue, then mem_done -> no done pulse, busy=0, FSM IDLE.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Shares one single-outstanding memory port among PORT_COUNT requesters.
//   Each port's read/write request is latched into a pending slot. Slots are granted one at a
//   time with rotating priority, and the winner is forwarded downstream as a one-cycle request.
//   Read data and a one-cycle done pulse are returned to the port that owns the transaction.
//
// Ports
//   CLK, RST      clock (rising edge) and synchronous active-high reset
//   rw_flag_      per-port request, 2 bits each: 0 none, 1 read, 2 write, 3 treated as none
//   addr_         per-port address, ADDR_WIDTH bits each
//   write_data_   per-port write data, DATA_WIDTH bits each
//   write_mask_   per-port byte write mask, DATA_WIDTH/8 bits each
//   read_data_    per-port last read result, held until the next read on that port
//   busy          port has an accepted request that has not completed yet
//   done          one-cycle completion pulse per port
//   mem_rw_flag   downstream request, nonzero for exactly one cycle per issue
//   mem_addr      downstream address, valid with mem_rw_flag
//   mem_wdata     downstream write data
//   mem_mask      downstream write mask
//   mem_busy      downstream cannot accept an issue this cycle
//   mem_done      downstream completion pulse
//   mem_rdata     downstream read data, valid with mem_done

module mem_rr_arbiter #(
   parameter int unsigned PORT_COUNT = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic [2*PORT_COUNT-1:0]              rw_flag_,
   input  logic [ADDR_WIDTH*PORT_COUNT-1:0]     addr_,
   input  logic [DATA_WIDTH*PORT_COUNT-1:0]     write_data_,
   input  logic [(DATA_WIDTH/8)*PORT_COUNT-1:0] write_mask_,
   output logic [DATA_WIDTH*PORT_COUNT-1:0]     read_data_,
   output logic [PORT_COUNT-1:0]                busy,
   output logic [PORT_COUNT-1:0]                done,
   output logic [1:0]                           mem_rw_flag,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   output logic [DATA_WIDTH-1:0]                mem_wdata,
   output logic [DATA_WIDTH/8-1:0]              mem_mask,
   input  logic                                 mem_busy,
   input  logic                                 mem_done,
   input  logic [DATA_WIDTH-1:0]                mem_rdata
);

   localparam int unsigned MW = DATA_WIDTH / 8;
   localparam int unsigned PW = $clog2(PORT_COUNT);

   localparam logic [1:0] FlagNone  = 2'd0;
   localparam logic [1:0] FlagRead  = 2'd1;
   localparam logic [1:0] FlagWrite = 2'd2;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e state_q, state_d;

   // Pending slots; a valid slot stays valid while its transaction is in flight,
   // so pend_valid doubles as the busy indication.
   logic [PORT_COUNT-1:0]                 pend_valid_q, pend_valid_d;
   logic [PORT_COUNT-1:0][1:0]            pend_flag_q,  pend_flag_d;
   logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] pend_addr_q,  pend_addr_d;
   logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] pend_data_q,  pend_data_d;
   logic [PORT_COUNT-1:0][MW-1:0]         pend_mask_q,  pend_mask_d;

   logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [PORT_COUNT-1:0]                 done_q,  done_d;

   logic [PW-1:0] last_q, last_d;   // most recently completed port
   logic [PW-1:0] serv_q, serv_d;   // port owning the outstanding transaction

   logic [1:0]            mem_rw_flag_q, mem_rw_flag_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;
   logic [MW-1:0]         mem_mask_q,    mem_mask_d;

   // ------------------------------------------------------------------
   // Round-robin pick among pending slots, starting just after last_q
   // ------------------------------------------------------------------
   logic          grant_valid;
   logic [PW-1:0] grant_idx;

   always_comb begin : p_arb
      int unsigned cand;
      cand        = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         cand = (32'(last_q) + 1 + i) % PORT_COUNT;
         if (!grant_valid && pend_valid_q[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = PW'(cand);
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin : p_next
      state_d       = state_q;
      pend_valid_d  = pend_valid_q;
      pend_flag_d   = pend_flag_q;
      pend_addr_d   = pend_addr_q;
      pend_data_d   = pend_data_q;
      pend_mask_d   = pend_mask_q;
      rdata_d       = rdata_q;
      done_d        = '0;
      last_d        = last_q;
      serv_d        = serv_q;
      mem_rw_flag_d = FlagNone;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_mask_d    = mem_mask_q;

      // Accept new requests on idle ports; requests on busy ports are dropped and the
      // requester re-presents after its done pulse.
      for (int p = 0; p < PORT_COUNT; p++) begin
         if (!pend_valid_q[p] &&
             ((rw_flag_[2*p +: 2] == FlagRead) || (rw_flag_[2*p +: 2] == FlagWrite))) begin
            pend_valid_d[p] = 1'b1;
            pend_flag_d[p]  = rw_flag_[2*p +: 2];
            pend_addr_d[p]  = addr_[ADDR_WIDTH*p +: ADDR_WIDTH];
            pend_data_d[p]  = write_data_[DATA_WIDTH*p +: DATA_WIDTH];
            pend_mask_d[p]  = write_mask_[MW*p +: MW];
         end
      end

      case (state_q)
         StIdle: begin
            // mem_done here is stray (e.g. after a reset abandoned a transaction); ignore it.
            if (grant_valid && !mem_busy) begin
               mem_rw_flag_d = pend_flag_q[grant_idx];
               mem_addr_d    = pend_addr_q[grant_idx];
               mem_wdata_d   = pend_data_q[grant_idx];
               mem_mask_d    = pend_mask_q[grant_idx];
               serv_d        = grant_idx;
               state_d       = StWait;
            end
         end
         StWait: begin
            if (mem_done) begin
               done_d[serv_q]       = 1'b1;
               pend_valid_d[serv_q] = 1'b0;
               if (pend_flag_q[serv_q] == FlagRead) begin
                  rdata_d[serv_q] = mem_rdata;
               end
               last_d  = serv_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= StIdle;
         pend_valid_q  <= '0;
         pend_flag_q   <= '0;
         pend_addr_q   <= '0;
         pend_data_q   <= '0;
         pend_mask_q   <= '0;
         rdata_q       <= '0;
         done_q        <= '0;
         last_q        <= PW'(PORT_COUNT - 1);
         serv_q        <= '0;
         mem_rw_flag_q <= FlagNone;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_mask_q    <= '0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_flag_q   <= pend_flag_d;
         pend_addr_q   <= pend_addr_d;
         pend_data_q   <= pend_data_d;
         pend_mask_q   <= pend_mask_d;
         rdata_q       <= rdata_d;
         done_q        <= done_d;
         last_q        <= last_d;
         serv_q        <= serv_d;
         mem_rw_flag_q <= mem_rw_flag_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_mask_q    <= mem_mask_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign read_data_  = rdata_q;
   assign busy        = pend_valid_q;
   assign done        = done_q;
   assign mem_rw_flag = mem_rw_flag_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_mask    = mem_mask_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed bench for mem_rr_arbiter (4 ports, 32-bit address/data). Each task drives one
//   scenario and compares DUT outputs against hand-computed values; inputs change and outputs
//   are sampled 1ns after each rising edge.

module tb_mem_rr_arbiter;

   logic         CLK;
   logic         RST;
   logic [7:0]   rw_flag_;
   logic [127:0] addr_;
   logic [127:0] write_data_;
   logic [15:0]  write_mask_;
   logic [127:0] read_data_;
   logic [3:0]   busy;
   logic [3:0]   done;
   logic [1:0]   mem_rw_flag;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_mask;
   logic         mem_busy;
   logic         mem_done;
   logic [31:0]  mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_rr_arbiter #(
      .PORT_COUNT(4),
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .rw_flag_    (rw_flag_),
      .addr_       (addr_),
      .write_data_ (write_data_),
      .write_mask_ (write_mask_),
      .read_data_  (read_data_),
      .busy        (busy),
      .done        (done),
      .mem_rw_flag (mem_rw_flag),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_mask    (mem_mask),
      .mem_busy    (mem_busy),
      .mem_done    (mem_done),
      .mem_rdata   (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST      = 1'b1;
      rw_flag_ = '0;
      mem_done = 1'b0;
      mem_busy = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   // Reset held two cycles with every port requesting; port 0 wins first after release.
   task automatic test_reset();
      RST      = 1'b1;
      rw_flag_ = 8'h55;
      for (int p = 0; p < 4; p++) addr_[32*p +: 32] = 32'h1000 + 32'(p) * 16;
      tick();
      tick();
      n_checks++;
      if (busy !== 4'h0) begin
         n_fail++; $display("FAIL reset_busy: got %h want %h", busy, 4'h0);
      end
      n_checks++;
      if (done !== 4'h0) begin
         n_fail++; $display("FAIL reset_done: got %h want %h", done, 4'h0);
      end
      n_checks++;
      if (mem_rw_flag !== 2'd0) begin
         n_fail++; $display("FAIL reset_mem_rw_flag: got %0d want 0", mem_rw_flag);
      end
      n_checks++;
      if (read_data_ !== 128'd0) begin
         n_fail++; $display("FAIL reset_read_data: got %h want 0", read_data_);
      end
      RST = 1'b0;
      tick();
      n_checks++;
      if (busy !== 4'hF || mem_rw_flag !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_accept: got busy=%h flag=%0d want busy=f flag=0", busy, mem_rw_flag);
      end
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd1 || mem_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL reset_first_grant: got flag=%0d addr=%h want flag=1 addr=00001000",
                  mem_rw_flag, mem_addr);
      end
      rw_flag_ = '0;
   endtask

   // Port 2 read, downstream completes 3 cycles after the issue cycle.
   task automatic test_single_read();
      do_reset();
      addr_[64 +: 32] = 32'h100;
      rw_flag_[5:4]   = 2'd1;
      tick();                                   // T+1: accepted
      rw_flag_ = '0;
      n_checks++;
      if (busy !== 4'b0100 || mem_rw_flag !== 2'd0) begin
         n_fail++;
         $display("FAIL read_accept: got busy=%h flag=%0d want busy=4 flag=0", busy, mem_rw_flag);
      end
      tick();                                   // T+2: issue
      n_checks++;
      if (mem_rw_flag !== 2'd1 || mem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL read_issue: got flag=%0d addr=%h want flag=1 addr=00000100",
                  mem_rw_flag, mem_addr);
      end
      tick();                                   // T+3: one-cycle request
      n_checks++;
      if (mem_rw_flag !== 2'd0) begin
         n_fail++; $display("FAIL read_issue_pulse: got %0d want 0", mem_rw_flag);
      end
      tick();                                   // T+4
      tick();                                   // T+5: downstream done
      mem_done  = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      n_checks++;
      if (done !== 4'h0 || busy !== 4'b0100) begin
         n_fail++;
         $display("FAIL read_wait: got done=%h busy=%h want done=0 busy=4", done, busy);
      end
      tick();                                   // T+6: done visible
      mem_done = 1'b0;
      n_checks++;
      if (done !== 4'b0100 || busy !== 4'h0) begin
         n_fail++;
         $display("FAIL read_done: got done=%h busy=%h want done=4 busy=0", done, busy);
      end
      n_checks++;
      if (read_data_[95:64] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL read_data: got %h want deadbeef", read_data_[95:64]);
      end
      tick();
      n_checks++;
      if (done !== 4'h0) begin
         n_fail++; $display("FAIL read_done_pulse: got %h want 0", done);
      end
   endtask

   // All ports keep requesting; grants must rotate 0,1,2,3,0,1,2,3.
   task automatic test_fairness();
      do_reset();
      for (int p = 0; p < 4; p++) addr_[32*p +: 32] = 32'h2000 + 32'(p) * 4;
      rw_flag_ = 8'h55;
      for (int n = 0; n < 8; n++) begin
         int unsigned waited;
         waited = 0;
         while (mem_rw_flag == 2'd0 && waited < 20) begin
            tick();
            waited++;
         end
         n_checks++;
         if (mem_rw_flag !== 2'd1 || mem_addr !== 32'h2000 + 32'(n % 4) * 4) begin
            n_fail++;
            $display("FAIL fair_grant %0d: got flag=%0d addr=%h want flag=1 addr=%h", n,
                     mem_rw_flag, mem_addr, 32'h2000 + 32'(n % 4) * 4);
         end
         tick();
         mem_done  = 1'b1;
         mem_rdata = 32'hA000_0000 + 32'(n);
         tick();
         mem_done = 1'b0;
         n_checks++;
         if (done !== 4'(1 << (n % 4))) begin
            n_fail++;
            $display("FAIL fair_done %0d: got %h want %h", n, done, 4'(1 << (n % 4)));
         end
         n_checks++;
         if (read_data_[32*(n % 4) +: 32] !== 32'hA000_0000 + 32'(n)) begin
            n_fail++;
            $display("FAIL fair_rdata %0d: got %h want %h", n, read_data_[32*(n % 4) +: 32],
                     32'hA000_0000 + 32'(n));
         end
      end
      rw_flag_ = '0;
   endtask

   // Port 1 write; read_data_ for port 1 must not pick up mem_rdata.
   task automatic test_write();
      do_reset();
      addr_[32 +: 32]       = 32'h20;
      write_data_[32 +: 32] = 32'h11223344;
      write_mask_[7:4]      = 4'b0011;
      rw_flag_[3:2]         = 2'd2;
      tick();
      rw_flag_ = '0;
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd2 || mem_addr !== 32'h20 || mem_wdata !== 32'h11223344 ||
          mem_mask !== 4'b0011) begin
         n_fail++;
         $display("FAIL write_issue: got flag=%0d addr=%h data=%h mask=%b want 2/20/11223344/0011",
                  mem_rw_flag, mem_addr, mem_wdata, mem_mask);
      end
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd0) begin
         n_fail++; $display("FAIL write_issue_pulse: got %0d want 0", mem_rw_flag);
      end
      mem_done  = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_done = 1'b0;
      n_checks++;
      if (done !== 4'b0010 || busy !== 4'h0) begin
         n_fail++;
         $display("FAIL write_done: got done=%h busy=%h want done=2 busy=0", done, busy);
      end
      n_checks++;
      if (read_data_[63:32] !== 32'h0) begin
         n_fail++; $display("FAIL write_rdata_kept: got %h want 0", read_data_[63:32]);
      end
   endtask

   // Downstream busy for 10 cycles with port 3 pending, plus a stray mem_done while idle.
   task automatic test_backpressure();
      int issued;
      int stray;
      issued = 0;
      stray  = 0;
      do_reset();
      mem_busy        = 1'b1;
      addr_[96 +: 32] = 32'h300;
      rw_flag_[7:6]   = 2'd1;
      tick();
      rw_flag_ = '0;
      for (int i = 0; i < 10; i++) begin
         mem_done = (i == 4);
         tick();
         if (mem_rw_flag !== 2'd0) issued++;
         if (done !== 4'h0) stray++;
      end
      mem_done = 1'b0;
      n_checks++;
      if (issued !== 0) begin
         n_fail++; $display("FAIL bp_no_issue: got %0d issue cycles want 0", issued);
      end
      n_checks++;
      if (stray !== 0) begin
         n_fail++; $display("FAIL bp_stray_done: got %0d done cycles want 0", stray);
      end
      n_checks++;
      if (busy !== 4'b1000) begin
         n_fail++; $display("FAIL bp_busy_held: got %h want 8", busy);
      end
      mem_busy = 1'b0;
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd1 || mem_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL bp_release_issue: got flag=%0d addr=%h want flag=1 addr=00000300",
                  mem_rw_flag, mem_addr);
      end
      tick();
      mem_done  = 1'b1;
      mem_rdata = 32'h0000_0333;
      tick();
      mem_done = 1'b0;
      n_checks++;
      if (done !== 4'b1000) begin
         n_fail++; $display("FAIL bp_done: got %h want 8", done);
      end
   endtask

   // Reset while waiting on downstream; the late mem_done must be ignored.
   task automatic test_reset_mid_wait();
      do_reset();
      addr_[0 +: 32] = 32'h600;
      rw_flag_[1:0]  = 2'd1;
      tick();
      rw_flag_ = '0;
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd1) begin
         n_fail++; $display("FAIL midrst_issue: got %0d want 1", mem_rw_flag);
      end
      RST = 1'b1;
      tick();
      RST       = 1'b0;
      mem_done  = 1'b1;
      mem_rdata = 32'hFFFF0000;
      tick();
      mem_done = 1'b0;
      n_checks++;
      if (done !== 4'h0 || busy !== 4'h0) begin
         n_fail++;
         $display("FAIL midrst_after_done: got done=%h busy=%h want 0/0", done, busy);
      end
      n_checks++;
      if (read_data_[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL midrst_rdata: got %h want 0", read_data_[31:0]);
      end
      tick();
      n_checks++;
      if (done !== 4'h0 || mem_rw_flag !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_quiet: got done=%h flag=%0d want 0/0", done, mem_rw_flag);
      end
      // FSM must be idle again: a fresh request issues with normal latency.
      addr_[32 +: 32] = 32'h610;
      rw_flag_[3:2]   = 2'd1;
      tick();
      rw_flag_ = '0;
      tick();
      n_checks++;
      if (mem_rw_flag !== 2'd1 || mem_addr !== 32'h610) begin
         n_fail++;
         $display("FAIL midrst_idle_issue: got flag=%0d addr=%h want flag=1 addr=00000610",
                  mem_rw_flag, mem_addr);
      end
   endtask

   initial begin
      RST         = 1'b1;
      rw_flag_    = '0;
      addr_       = '0;
      write_data_ = '0;
      write_mask_ = '0;
      mem_busy    = 1'b0;
      mem_done    = 1'b0;
      mem_rdata   = '0;
      test_reset();
      test_single_read();
      test_fairness();
      test_write();
      test_backpressure();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
